// File: rtl/router_fifo.sv
// router_fifo: per-port output buffer of the 1x3 router.
// Stores {header flag, byte} entries and tracks packet length on the read side.
//
// Ports:
//   clock       rising-edge clock
//   resetn      asynchronous active-low reset
//   soft_reset  synchronous flush, active-high
//   write_enb   write request (ignored while full)
//   read_enb    read request (ignored while empty)
//   lfd_state   high when data_in is a header byte
//   data_in     byte to store
//   data_out    registered read data (1-cycle latency)
//   full        no free entry
//   empty       no stored entry
module router_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  read_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [6:0]          pkt_cnt;
    logic [DATA_WIDTH:0] rd_entry;
    logic                wr_acc;
    logic                rd_acc;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    assign wr_acc   = write_enb && !full;
    assign rd_acc   = read_enb && !empty;
    assign rd_entry = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // Storage array is deliberately not reset.
    always_ff @(posedge clock) begin
        if (!soft_reset && wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
        end else if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
        end else if (soft_reset) begin
            rd_ptr <= '0;
        end else if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Header byte carries payload length in bits [7:2]; +1 covers parity.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_cnt <= '0;
        end else if (soft_reset) begin
            pkt_cnt <= '0;
        end else if (rd_acc) begin
            if (rd_entry[DATA_WIDTH]) begin
                pkt_cnt <= 7'(rd_entry[DATA_WIDTH-1:2]) + 7'd1;
            end else if (pkt_cnt != 7'd0) begin
                pkt_cnt <= pkt_cnt - 7'd1;
            end
        end
    end

    // Output returns to zero once a packet has fully drained and no read occurs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out <= '0;
        end else if (soft_reset) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= rd_entry[DATA_WIDTH-1:0];
        end else if (pkt_cnt == 7'd0) begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: randomized + directed bench for router_fifo.
// Queue-based reference model feeds a scoreboard checked by a monitor.
module tb_router_fifo;

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    router_fifo #(
        .DATA_WIDTH(8),
        .DEPTH     (16),
        .ADDR_WIDTH(4)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .soft_reset(soft_reset),
        .write_enb (write_enb),
        .read_enb  (read_enb),
        .lfd_state (lfd_state),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty)
    );

    typedef struct {
        logic [7:0] dout;
        logic       emp;
        logic       ful;
        logic [6:0] pkt;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] mq[$];
    logic [6:0] m_pkt;
    logic [7:0] m_dout;
    int         checks;
    int         failures;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, expv, $time);
        end
    endtask

    // Monitor: compare DUT outputs just after each active edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("data_out", {24'd0, data_out}, {24'd0, e.dout});
            chk("empty", {31'd0, empty}, {31'd0, e.emp});
            chk("full", {31'd0, full}, {31'd0, e.ful});
            chk("pkt_cnt", {25'd0, dut.pkt_cnt}, {25'd0, e.pkt});
        end
    end

    // One clock of stimulus; the model advances by the same edge.
    task automatic cycle(input logic we, input logic re, input logic lfd,
                         input logic [7:0] d, input logic sr);
        exp_t e;
        logic [8:0] ent;
        logic m_full;
        logic m_empty;
        @(negedge clock);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = d;
        soft_reset = sr;
        if (sr) begin
            mq.delete();
            m_pkt  = 7'd0;
            m_dout = 8'd0;
        end else begin
            m_full  = (mq.size() == 16);
            m_empty = (mq.size() == 0);
            if (re && !m_empty) begin
                ent    = mq.pop_front();
                m_dout = ent[7:0];
                if (ent[8]) m_pkt = {1'b0, ent[7:2]} + 7'd1;
                else if (m_pkt != 0) m_pkt = m_pkt - 7'd1;
            end else if (m_pkt == 0) begin
                m_dout = 8'd0;
            end
            if (we && !m_full) mq.push_back({lfd, d});
        end
        e.dout = m_dout;
        e.emp  = (mq.size() == 0);
        e.ful  = (mq.size() == 16);
        e.pkt  = m_pkt;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic lfd, input logic [7:0] d);
        cycle(1'b1, 1'b0, lfd, d, 1'b0);
    endtask

    task automatic rd();
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Assert reset between edges and check outputs before any edge.
    task automatic async_reset();
        @(negedge clock);
        write_enb = 1'b0;
        read_enb  = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        mq.delete();
        m_pkt  = 7'd0;
        m_dout = 8'd0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        m_pkt      = 7'd0;
        m_dout     = 8'd0;
        resetn     = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        async_reset();
        idle();

        // Fill, overflow attempt, drain in order.
        for (int i = 1; i <= 16; i++) wr(1'b0, 8'(i));
        wr(1'b0, 8'h77);
        for (int i = 0; i < 16; i++) rd();
        rd();
        idle();

        // Packet with header, payload and parity; end-of-packet clear.
        wr(1'b1, 8'h0D);
        wr(1'b0, 8'hA1);
        wr(1'b0, 8'hA2);
        wr(1'b0, 8'hA3);
        wr(1'b0, 8'h55);
        for (int i = 0; i < 5; i++) rd();
        idle();
        idle();

        // Full with simultaneous read and write.
        for (int i = 0; i < 16; i++) wr(1'b0, 8'($urandom));
        cycle(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
        for (int i = 0; i < 16; i++) rd();
        idle();

        // Wrap: interleaved pairs and simultaneous pairs with backlog.
        for (int i = 0; i < 40; i++) begin
            wr(1'b0, 8'(8'h80 + i));
            rd();
        end
        for (int i = 0; i < 3; i++) wr(1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) rd();

        // Soft reset mid-packet with 5 bytes still stored.
        wr(1'b1, 8'h14);
        for (int i = 0; i < 6; i++) wr(1'b0, 8'(8'hC0 + i));
        rd();
        rd();
        cycle(1'b1, 1'b1, 1'b0, 8'h99, 1'b1);
        wr(1'b1, 8'h0D);
        rd();
        idle();

        // Async reset with nonzero output and stored data.
        wr(1'b0, 8'h5A);
        wr(1'b0, 8'h6B);
        wr(1'b1, 8'h10);
        rd();
        async_reset();
        idle();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0),
                  8'($urandom),
                  1'($urandom_range(0, 63) == 0));
        end

        idle();
        @(negedge clock);
        @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
